// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan address generator.
// Pure declarations; no logic, no timing, no flow control.
package scan_pkg;

  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] ADDR_MAX = 3'd7;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a, input logic down);
    return down ? (a - ADDR_W'(1)) : (a + ADDR_W'(1));
  endfunction

  // True when stepping from a in the given direction crosses the 7/0 seam.
  function automatic logic addr_wraps(input logic [ADDR_W-1:0] a, input logic down);
    return down ? (a == '0) : (a == ADDR_MAX);
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Divides clk by DIV_CNT; tick is a combinational pulse in the terminal-count cycle.
// Zero latency on tick; en=0 freezes the count, clr restarts it from 0 and suppresses tick.
module clk_prescaler #(
  parameter int DIV_CNT = 25000000,
  parameter int DIV_W   = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV_CNT - 1);

  logic [DIV_W-1:0] cnt_q;

  assign tick = en & ~clr & (cnt_q == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == TERM) ? '0 : (cnt_q + DIV_W'(1));
    end
  end

endmodule

// File: rtl/scan_addr_gen.sv
// 3-bit scan address for a 3-to-8 decoder, stepping every DIV_CNT cycles while running.
// All outputs registered; load > run > hold; SCAN_PINGPONG_EN adds bounce mode via pp.
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter int DIV_CNT = 25000000,
  parameter int DIV_W   = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       dir,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       pp,
  output logic       a2,
  output logic       a1,
  output logic       a0,
  output logic       step,
  output logic       wrap,
  output logic       busy
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                step_q, step_d;
  logic                wrap_q, wrap_d;
  logic                tick;

`ifdef SCAN_PINGPONG_EN
  logic                flag_q, flag_d;
  logic                pp_down;
`else
  logic                unused_pp;
  assign unused_pp = pp;
`endif

  // The prescaler counts on the registered state, so the cycle that leaves RUN still counts.
  clk_prescaler #(
    .DIV_CNT (DIV_CNT),
    .DIV_W   (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_RUN),
    .clr   (load),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
`ifdef SCAN_PINGPONG_EN
    flag_d  = flag_q;
    pp_down = flag_q;
`endif

    case (state_q)
      ST_IDLE: if (run)  state_d = ST_RUN;
      ST_RUN:  if (!run) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = state_q;
      addr_d  = load_val;
`ifdef SCAN_PINGPONG_EN
      flag_d  = DIR_UP;
`endif
    end else if (tick) begin
      step_d = 1'b1;
`ifdef SCAN_PINGPONG_EN
      if (pp) begin
        // Endpoints force the turn even if a load left the flag pointing outward.
        if (addr_q == ADDR_MAX)   pp_down = DIR_DOWN;
        else if (addr_q == '0)    pp_down = DIR_UP;
        addr_d = addr_next(addr_q, pp_down);
        if (addr_d == ADDR_MAX)   flag_d = DIR_DOWN;
        else if (addr_d == '0)    flag_d = DIR_UP;
        else                      flag_d = pp_down;
      end else begin
        addr_d = addr_next(addr_q, dir);
        wrap_d = addr_wraps(addr_q, dir);
      end
`else
      addr_d = addr_next(addr_q, dir);
      wrap_d = addr_wraps(addr_q, dir);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef SCAN_PINGPONG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= DIR_UP;
    else        flag_q <= flag_d;
  end
`endif

  assign {a2, a1, a0} = addr_q;
  assign step         = step_q;
  assign wrap         = wrap_q;
  assign busy         = (state_q == ST_RUN);

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed bench: DIV_CNT=4 main instance plus a DIV_CNT=1 instance for the every-cycle case.
module tb_scan_addr_gen;

  logic clk;
  logic rst_n;
  logic run, dir, load, pp;
  logic [2:0] load_val;
  logic a2, a1, a0, step, wrap, busy;

  logic run1, load1;
  logic b2, b1, b0, step1, wrap1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  int pp_seq [23] = '{1,2,3,4,5,6,7, 6,5,4,3,2,1,0, 1,2,3,4,5,6,7, 6,5};

  scan_addr_gen #(.DIV_CNT(4), .DIV_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .load(load), .load_val(load_val),
    .pp(pp), .a2(a2), .a1(a1), .a0(a0), .step(step), .wrap(wrap), .busy(busy)
  );

  scan_addr_gen #(.DIV_CNT(1), .DIV_W(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .dir(dir), .load(load1), .load_val(load_val),
    .pp(pp), .a2(b2), .a1(b1), .a0(b0), .step(step1), .wrap(wrap1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Three quiet edges then the stepping edge of a DIV_CNT=4 interval.
  task automatic step_check(input int exp_addr, input int exp_wrap);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("idle_step", step, 0);
      chk("idle_wrap", wrap, 0);
    end
    edge1();
    chk("step", step, 1);
    chk("addr", {a2, a1, a0}, exp_addr);
    chk("wrap", wrap, exp_wrap);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; dir = 1'b0; load = 1'b0; load_val = 3'd0; pp = 1'b0;
    run1 = 1'b0; load1 = 1'b0;

    #2;
    chk("rst_addr", {a2, a1, a0}, 0);
    chk("rst_step", step, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_busy", busy, 0);

    // Count up across the 7->0 seam.
    edge1();
    rst_n = 1'b1;
    run   = 1'b1;
    edge1();
    chk("enter_busy", busy, 1);
    chk("enter_step", step, 0);
    for (int k = 1; k <= 9; k++) step_check(k % 8, (k == 8) ? 1 : 0);
    chk("up_busy", busy, 1);

    // Reach address 2, then count down through 0->7.
    step_check(2, 0);
    dir = 1'b1;
    step_check(1, 0);
    step_check(0, 0);
    step_check(7, 1);
    step_check(6, 0);

    // Pause/resume from a cleared prescaler at address 0.
    dir = 1'b0;
    run = 1'b0;
    edge1();
    chk("stop_busy", busy, 0);
    load = 1'b1; load_val = 3'd0;
    edge1();
    load = 1'b0;
    chk("ld0_addr", {a2, a1, a0}, 0);
    chk("ld0_step", step, 0);
    run = 1'b1;
    edge1();
    chk("p_busy_on", busy, 1);
    edge1();
    run = 1'b0;
    edge1();
    chk("p_busy_off", busy, 0);
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk("hold_addr", {a2, a1, a0}, 0);
      chk("hold_step", step, 0);
      chk("hold_busy", busy, 0);
    end
    run = 1'b1;
    edge1();
    chk("res_busy", busy, 1);
    chk("res_step0", step, 0);
    edge1();
    chk("res_step1", step, 0);
    edge1();
    chk("res_step2", step, 1);
    chk("res_addr", {a2, a1, a0}, 1);

    // Load on the terminal-count edge wins.
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("pre_ld_step", step, 0);
    end
    load = 1'b1; load_val = 3'd5;
    edge1();
    load = 1'b0;
    chk("ldt_addr", {a2, a1, a0}, 5);
    chk("ldt_step", step, 0);
    chk("ldt_wrap", wrap, 0);
    step_check(6, 0);

    // Asynchronous reset while step is high at address 6.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", {a2, a1, a0}, 0);
    chk("arst_step", step, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_busy", busy, 0);
    edge1();
    chk("arst_hold_step", step, 0);
    rst_n = 1'b1;
    edge1();
    chk("post_rst_step", step, 0);
    chk("post_rst_addr", {a2, a1, a0}, 0);
    chk("post_rst_busy", busy, 1);
    step_check(1, 0);

    // DIV_CNT=1: a new address every cycle, step held high.
    run1 = 1'b1;
    edge1();
    chk("d1_busy", busy1, 1);
    chk("d1_first_step", step1, 0);
    for (int k = 2; k <= 9; k++) begin
      edge1();
      chk("d1_addr", {b2, b1, b0}, (k - 1) % 8);
      chk("d1_step", step1, 1);
      chk("d1_wrap", wrap1, (k == 9) ? 1 : 0);
    end
    load_val = 3'd5; load1 = 1'b1;
    edge1();
    load1 = 1'b0;
    chk("d1_ld_addr", {b2, b1, b0}, 5);
    chk("d1_ld_step", step1, 0);
    edge1();
    chk("d1_after_ld", {b2, b1, b0}, 6);
    chk("d1_after_step", step1, 1);

`ifdef SCAN_PINGPONG_EN
    pp = 1'b1;
    load = 1'b1; load_val = 3'd0;
    edge1();
    load = 1'b0;
    chk("pp_ld_addr", {a2, a1, a0}, 0);
    for (int i = 0; i < 23; i++) step_check(pp_seq[i], 0);
    load = 1'b1; load_val = 3'd3;
    edge1();
    load = 1'b0;
    chk("pp_ld3_addr", {a2, a1, a0}, 3);
    chk("pp_ld3_step", step, 0);
    step_check(4, 0);
    step_check(5, 0);
`else
    // pp has no effect without the bounce feature: a plain 7->0 wrap.
    pp = 1'b1;
    load = 1'b1; load_val = 3'd7;
    edge1();
    load = 1'b0;
    chk("ppx_ld_addr", {a2, a1, a0}, 7);
    step_check(0, 1);
    step_check(1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
